// File: rtl/tdm_demux4_pkg.sv
// Shared constants and state type for the 4-slot TDM demultiplexer.
package tdm_demux4_pkg;
   localparam int NUM_SLOTS = 4;
   localparam int SLOT_W    = 2;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_e;
endpackage

// File: rtl/tdm_slot_counter.sv
// Slot index counter: load-to-1 on a frame start, increment with natural wrap 3->0.
module tdm_slot_counter
   import tdm_demux4_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load1_i,
   input  logic              inc_i,
   output logic [SLOT_W-1:0] slot_o
);
   logic [SLOT_W-1:0] slot_q, slot_d;

   always_comb begin
      slot_d = slot_q;
      if (load1_i)    slot_d = SLOT_W'(1);
      else if (inc_i) slot_d = slot_q + SLOT_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) slot_q <= '0;
      else       slot_q <= slot_d;
   end

   assign slot_o = slot_q;
endmodule

// File: rtl/tdm_demux4.sv
// 4-slot TDM demultiplexer: hunts for frame_sync, collects slots 0-2 in shadows,
// and publishes all four lanes on the edge that accepts slot 3.
module tdm_demux4
   import tdm_demux4_pkg::*;
#(
   parameter int W = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [W-1:0]      din,
   input  logic              din_valid,
   input  logic              frame_sync,
   output logic [W-1:0]      out0,
   output logic [W-1:0]      out1,
   output logic [W-1:0]      out2,
   output logic [W-1:0]      out3,
   output logic              frame_valid,
   output logic              sync_err,
   output logic              locked,
   output logic [SLOT_W-1:0] slot
);
   state_e            state_q;
   logic [W-1:0]      sh0_q, sh1_q, sh2_q;
   logic [W-1:0]      out0_q, out1_q, out2_q, out3_q;
   logic              fv_q, err_q;
   logic              load1, inc;
   logic [SLOT_W-1:0] slot_q;

   // A frame_sync always restarts at slot 1; otherwise only a locked, mid-frame slot advances.
   always_comb begin
      load1 = 1'b0;
      inc   = 1'b0;
      if (din_valid) begin
         if (frame_sync)                                  load1 = 1'b1;
         else if (state_q == LOCKED && slot_q != '0)      inc   = 1'b1;
      end
   end

   tdm_slot_counter u_slot_cnt (
      .clk     (clk),
      .reset   (reset),
      .load1_i (load1),
      .inc_i   (inc),
      .slot_o  (slot_q)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         sh0_q   <= '0;
         sh1_q   <= '0;
         sh2_q   <= '0;
         out0_q  <= '0;
         out1_q  <= '0;
         out2_q  <= '0;
         out3_q  <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         fv_q  <= 1'b0;
         err_q <= 1'b0;
         if (din_valid) begin
            if (frame_sync) begin
               // Sync mid-frame drops the partial frame but stays locked.
               if (state_q == LOCKED && slot_q != '0) err_q <= 1'b1;
               sh0_q   <= din;
               state_q <= LOCKED;
            end else if (state_q == LOCKED) begin
               case (slot_q)
                  2'd0: begin
                     err_q   <= 1'b1;
                     state_q <= HUNT;
                  end
                  2'd1: sh1_q <= din;
                  2'd2: sh2_q <= din;
                  default: begin
                     out0_q <= sh0_q;
                     out1_q <= sh1_q;
                     out2_q <= sh2_q;
                     out3_q <= din;
                     fv_q   <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   assign out0        = out0_q;
   assign out1        = out1_q;
   assign out2        = out2_q;
   assign out3        = out3_q;
   assign frame_valid = fv_q;
   assign sync_err    = err_q;
   assign locked      = (state_q == LOCKED);
   assign slot        = slot_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed framing scenarios plus random traffic against a frame-level model.
module tb_tdm_demux4;
   localparam int W = 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din;
   logic         din_valid;
   logic         frame_sync;
   logic [W-1:0] out0, out1, out2, out3;
   logic         frame_valid, sync_err, locked;
   logic [1:0]   slot;

   tdm_demux4 #(.W(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .frame_sync  (frame_sync),
      .out0        (out0),
      .out1        (out1),
      .out2        (out2),
      .out3        (out3),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .locked      (locked),
      .slot        (slot)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int fv_cyc[$];

   // Frame-level model: a list of collected samples and a locked flag.
   logic [W-1:0] part[$];
   logic [W-1:0] m_out[4];
   bit           m_locked, m_fv, m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      part.delete();
      for (int i = 0; i < 4; i++) m_out[i] = '0;
      m_locked = 0; m_fv = 0; m_err = 0;
   endtask

   task automatic model_step(input logic v, input logic fs, input logic [W-1:0] d);
      m_fv = 0; m_err = 0;
      if (!v) return;
      if (fs) begin
         if (m_locked && part.size() != 0) m_err = 1;
         part.delete();
         part.push_back(d);
         m_locked = 1;
      end else if (m_locked) begin
         if (part.size() == 0) begin
            m_err = 1;
            m_locked = 0;
         end else begin
            part.push_back(d);
            if (part.size() == 4) begin
               for (int i = 0; i < 4; i++) m_out[i] = part[i];
               part.delete();
               m_fv = 1;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out0"}, 32'(out0), 32'(m_out[0]));
      chk({tag, ".out1"}, 32'(out1), 32'(m_out[1]));
      chk({tag, ".out2"}, 32'(out2), 32'(m_out[2]));
      chk({tag, ".out3"}, 32'(out3), 32'(m_out[3]));
      chk({tag, ".fv"},   32'(frame_valid), 32'(m_fv));
      chk({tag, ".err"},  32'(sync_err), 32'(m_err));
      chk({tag, ".lock"}, 32'(locked), 32'(m_locked));
      chk({tag, ".slot"}, 32'(slot), 32'(part.size()));
   endtask

   task automatic step(input string tag, input logic v, input logic fs, input logic [W-1:0] d);
      din = d; din_valid = v; frame_sync = fs;
      @(posedge clk);
      cyc++;
      model_step(v, fs, d);
      #1;
      if (frame_valid) fv_cyc.push_back(cyc);
      check_all(tag);
   endtask

   task automatic frame(input string tag, input logic [3:0] s);
      step(tag, 1, 1, s[3]);
      step(tag, 1, 0, s[2]);
      step(tag, 1, 0, s[1]);
      step(tag, 1, 0, s[0]);
   endtask

   // Reset pulse placed between edges; outputs must clear without waiting for a clock.
   task automatic pulse_reset(input string tag);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all({tag, ".async"});
      @(posedge clk);
      #1 check_all({tag, ".hold"});
      reset = 1'b0;
   endtask

   int start;

   initial begin
      reset = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
      model_reset();
      #3 check_all("rst");
      @(posedge clk);
      #1 check_all("rst_edge");
      reset = 1'b0;

      // Basic frame 1,0,1,0
      fv_cyc.delete();
      frame("f1", 4'b1010);
      chk("f1.fv_count", 32'(fv_cyc.size()), 32'd1);
      chk("f1.locked", 32'(locked), 32'd1);
      step("f1_idle", 0, 0, 1);

      // Same frame with two idle cycles between slots 1 and 2
      fv_cyc.delete();
      start = cyc;
      step("gap", 1, 1, 1);
      step("gap", 1, 0, 0);
      step("gap", 0, 1, 1);
      step("gap", 0, 0, 0);
      step("gap", 1, 0, 1);
      step("gap", 1, 0, 0);
      chk("gap.fv_count", 32'(fv_cyc.size()), 32'd1);
      if (fv_cyc.size() > 0) chk("gap.fv_delay", 32'(fv_cyc[0] - start), 32'd6);

      // Back-to-back frames
      fv_cyc.delete();
      frame("b2b", 4'b1010);
      frame("b2b", 4'b0110);
      chk("b2b.fv_count", 32'(fv_cyc.size()), 32'd2);
      if (fv_cyc.size() == 2) chk("b2b.fv_gap", 32'(fv_cyc[1] - fv_cyc[0]), 32'd4);

      // frame_sync arriving at slot 2
      fv_cyc.delete();
      step("late", 1, 1, 1);
      step("late", 1, 0, 1);
      step("late", 1, 1, 0);
      chk("late.err", 32'(sync_err), 32'd1);
      chk("late.locked", 32'(locked), 32'd1);
      step("late", 1, 0, 0);
      step("late", 1, 0, 1);
      step("late", 1, 0, 1);
      chk("late.fv_out", 32'({out0, out1, out2, out3}), 32'(4'b0011));

      // Missing frame_sync at slot 0 while locked
      step("miss", 1, 0, 1);
      chk("miss.err", 32'(sync_err), 32'd1);
      chk("miss.locked", 32'(locked), 32'd0);
      for (int i = 0; i < 5; i++) step("miss_ign", 1, 0, 1);
      frame("relock", 4'b1100);

      // Reset after slot 2 of a frame
      step("mid", 1, 1, 1);
      step("mid", 1, 0, 1);
      step("mid", 1, 0, 1);
      pulse_reset("mid_rst");
      fv_cyc.delete();
      for (int i = 0; i < 4; i++) step("post_rst", 1, 0, 1);
      chk("post_rst.fv_none", 32'(fv_cyc.size()), 32'd0);
      frame("post_rst_frame", 4'b0101);
      chk("post_rst.fv_one", 32'(fv_cyc.size()), 32'd1);

      // Random traffic, biased toward mostly well-formed frames
      for (int i = 0; i < 3000; i++) begin
         logic v, fs, d;
         v  = ($urandom_range(0, 3) != 0);
         fs = ($urandom_range(0, 11) == 0) ||
              (part.size() == 0 && $urandom_range(0, 5) != 0);
         d  = 1'($urandom);
         step("rnd", v, fs, d);
         if (i % 1000 == 999) pulse_reset("rnd_rst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
